// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, FSM state
// encodings and the default abort timeout.
package mem_stage_pkg;

  localparam int DataBusWidth         = 32;
  localparam int AddrBusWidth         = 32;
  localparam int RegAddrBusWidth      = 5;
  localparam int TimeoutCyclesDefault = 16;

  typedef enum logic [1:0] {
    MemIdle = 2'd0,
    MemWait = 2'd1,
    MemDone = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_timeout_counter.sv
// Counts consecutive WAIT cycles of an outstanding memory access and flags
// the cycle in which the access has waited TIMEOUT_CYCLES cycles.
// Only built when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CntW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // Next count: restart whenever the access is not waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current WAIT cycle is the last one allowed.
  assign expired_o = en_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mem_stage.sv
// Memory-access stage between EX/MEM and MEM/WB. Issues one registered
// req/ack transaction per load/store, stalls upstream while it is pending and
// hands load data or the ALU result to MEM/WB.
// Optional feature macro: MEM_TIMEOUT_EN (abort a WAIT after TIMEOUT_CYCLES).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DataBusWidth-1:0]    data_in,
  input  logic                       reg_write_en_in,
  input  logic [RegAddrBusWidth-1:0] reg_addr_in,
  input  logic                       mem_read_flag_in,
  input  logic                       mem_write_flag_in,
  input  logic [AddrBusWidth-1:0]    mem_addr_in,
  input  logic [DataBusWidth-1:0]    mem_write_data_in,
  input  logic                       hilo_write_en_in,
  input  logic [DataBusWidth-1:0]    hi_in,
  input  logic [DataBusWidth-1:0]    lo_in,
  input  logic                       stall_in,
  input  logic [DataBusWidth-1:0]    ram_rdata,
  input  logic                       ram_ack,
  output logic                       ram_req,
  output logic                       ram_we,
  output logic [AddrBusWidth-1:0]    ram_addr,
  output logic [DataBusWidth-1:0]    ram_wdata,
  output logic                       stall_req,
  output logic [DataBusWidth-1:0]    data_out,
  output logic                       reg_write_en_out,
  output logic [RegAddrBusWidth-1:0] reg_addr_out,
  output logic                       hilo_write_en_out,
  output logic [DataBusWidth-1:0]    hi_out,
  output logic [DataBusWidth-1:0]    lo_out,
  output logic                       mem_err_out
);

  mem_state_e                state_q, state_d;
  logic                      req_q, req_d;
  logic                      we_q, we_d;
  logic [AddrBusWidth-1:0]   addr_q, addr_d;
  logic [DataBusWidth-1:0]   wdata_q, wdata_d;
  logic [DataBusWidth-1:0]   load_buf_q, load_buf_d;
  logic                      is_load_q, is_load_d;
  logic                      access;
  logic                      timeout_exp;

  assign access = mem_read_flag_in | mem_write_flag_in;

`ifdef MEM_TIMEOUT_EN
  logic err_q;
  logic err_d;

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q != MemWait),
    .en_i     (state_q == MemWait),
    .expired_o(timeout_exp)
  );

  // An ack arriving in the last allowed cycle still completes normally.
  assign err_d = (state_q == MemWait) && !ram_ack && timeout_exp;

  // Abort flag lives for exactly the first DONE cycle after a timeout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign mem_err_out = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout_exp    = 1'b0;
  assign mem_err_out    = 1'b0;
`endif

  // Next-state and request-register logic for the IDLE/WAIT/DONE handshake.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    load_buf_d = load_buf_q;
    is_load_d  = is_load_q;
    unique case (state_q)
      MemIdle: begin
        if (access) begin
          req_d     = 1'b1;
          we_d      = mem_write_flag_in & ~mem_read_flag_in;
          addr_d    = mem_addr_in;
          wdata_d   = mem_write_data_in;
          is_load_d = mem_read_flag_in;
          state_d   = MemWait;
        end
      end
      MemWait: begin
        if (ram_ack) begin
          if (is_load_q) begin
            load_buf_d = ram_rdata;
          end
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = MemDone;
        end else if (timeout_exp) begin
          req_d      = 1'b0;
          we_d       = 1'b0;
          load_buf_d = '0;
          state_d    = MemDone;
        end
      end
      MemDone: begin
        // Never re-issue from DONE; the held instruction is already complete.
        if (!stall_in) begin
          state_d = MemIdle;
        end
      end
      default: state_d = MemIdle;
    endcase
  end

  // State and memory-port registers, all cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= MemIdle;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      load_buf_q <= '0;
      is_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      load_buf_q <= load_buf_d;
      is_load_q  <= is_load_d;
    end
  end

  assign ram_req   = req_q;
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  // Hold upstream from the issue cycle through the ack cycle; never in reset.
  assign stall_req = rst && (((state_q == MemIdle) && access) || (state_q == MemWait));

  assign data_out = ((state_q == MemDone) && is_load_q) ? load_buf_q : data_in;

  // Stalled or aborted cycles become bubbles in MEM/WB.
  assign reg_write_en_out  = reg_write_en_in  & ~stall_req & ~mem_err_out;
  assign hilo_write_en_out = hilo_write_en_in & ~stall_req & ~mem_err_out;

  assign reg_addr_out = reg_addr_in;
  assign hi_out       = hi_in;
  assign lo_out       = lo_in;

endmodule
